id_issue_scoreboard: RTL and testbench

Issue controller for the decode stage.
- Tracks which architectural registers have writes in flight between EX and WB, using a per-register pending-write counter scoreboard.
- Holds the decoded instruction in ID while any source it reads is still pending.
- Generates the ID-stage allowin/valid handshake and the one-cycle IF redirect pulse for taken branches.
- Sits beside the decode/regfile block: it consumes decoded register fields, and the WB write-back strobe retires entries.

---
 rtl/id_issue_scoreboard_pkg.sv | 17 +
 rtl/id_issue_scoreboard_sb_counter_array.sv | 58 +++++
 rtl/id_issue_scoreboard.sv | 87 ++++++++
 tb/tb_id_issue_scoreboard.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/id_issue_scoreboard_pkg.sv
// Shared sizing and register-index types for the decode-stage issue scoreboard.
package id_issue_scoreboard_pkg;

    localparam int NREG         = 32;
    localparam int CNT_W        = 2;
    localparam int MAX_INFLIGHT = 3;
    localparam int REG_IDX_W    = 5;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [CNT_W-1:0]     cnt_t;

    // r0 is hard-wired zero, so it never produces or resolves a hazard.
    function automatic logic is_tracked(input reg_idx_t r);
        return r != '0;
    endfunction

endpackage

// File: rtl/id_issue_scoreboard_sb_counter_array.sv
// Per-register pending-write counters with nonzero/full flags and underflow detection.
module sb_counter_array
    import id_issue_scoreboard_pkg::*;
(
    input  logic            clk,
    input  logic            resetn,
    input  logic            inc_en,
    input  reg_idx_t        inc_idx,
    input  logic            dec_en,
    input  reg_idx_t        dec_idx,
    output logic [NREG-1:0] nz,
    output logic [NREG-1:0] full,
    output logic            any_nz,
    output logic            underflow
);

    cnt_t cnt_q [NREG];
    cnt_t cnt_d [NREG];

    always_comb begin
        cnt_d     = cnt_q;
        underflow = 1'b0;
        if (inc_en && dec_en && (inc_idx == dec_idx)) begin
            // A write entering EX and one leaving WB cancel out on the same register.
            underflow = (cnt_q[dec_idx] == '0);
        end else begin
            if (inc_en) begin
                cnt_d[inc_idx] = cnt_q[inc_idx] + CNT_W'(1);
            end
            if (dec_en) begin
                if (cnt_q[dec_idx] == '0) begin
                    underflow = 1'b1;
                end else begin
                    cnt_d[dec_idx] = cnt_q[dec_idx] - CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        nz   = '0;
        full = '0;
        for (int i = 0; i < NREG; i++) begin
            nz[i]   = (cnt_q[i] != '0);
            full[i] = (cnt_q[i] == CNT_W'(MAX_INFLIGHT));
        end
        any_nz = |nz;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '{default: '0};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/id_issue_scoreboard.sv
// ID-stage issue control: RAW/full hazard detection, ID handshake, IF redirect pulse,
// sticky scoreboard error and stall-cycle counter.
module id_issue_scoreboard
    import id_issue_scoreboard_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        id_valid,
    input  logic [4:0]  id_raddr1,
    input  logic [4:0]  id_raddr2,
    input  logic        id_use_r1,
    input  logic        id_use_r2,
    input  logic        id_gr_we,
    input  logic [4:0]  id_dest,
    input  logic        id_br_taken,
    input  logic        ex_allowin,
    input  logic        wb_valid,
    input  logic        wb_rf_we,
    input  logic [4:0]  wb_waddr,
    output logic        id_allowin,
    output logic        id_to_ex_valid,
    output logic        id_stall,
    output logic        if_flush,
    output logic        sb_busy,
    output logic        sb_err,
    output logic [31:0] stall_cycles
);

    logic [NREG-1:0] nz;
    logic [NREG-1:0] full_flag;
    logic            any_nz;
    logic            underflow;

    logic raw1, raw2, full_hz, ready_go, issue;
    logic inc_en, dec_en;

    logic        sb_err_q, sb_err_d;
    logic [31:0] stall_cycles_q, stall_cycles_d;

    sb_counter_array u_cnt (
        .clk       (clk),
        .resetn    (resetn),
        .inc_en    (inc_en),
        .inc_idx   (id_dest),
        .dec_en    (dec_en),
        .dec_idx   (wb_waddr),
        .nz        (nz),
        .full      (full_flag),
        .any_nz    (any_nz),
        .underflow (underflow)
    );

    always_comb begin
        raw1     = id_use_r1 && is_tracked(id_raddr1) && nz[id_raddr1];
        raw2     = id_use_r2 && is_tracked(id_raddr2) && nz[id_raddr2];
        full_hz  = id_gr_we  && is_tracked(id_dest)   && full_flag[id_dest];
        ready_go = !(raw1 || raw2 || full_hz);

        // Handshake is forced to its idle view while reset is held, even if ID looks valid.
        issue          = resetn && id_valid && ready_go && ex_allowin;
        id_to_ex_valid = issue;
        id_allowin     = !resetn || !id_valid || issue;
        id_stall       = id_valid && !ready_go;
        if_flush       = issue && id_br_taken;

        inc_en = issue && id_gr_we && is_tracked(id_dest);
        dec_en = wb_valid && wb_rf_we && is_tracked(wb_waddr);

        sb_err_d       = sb_err_q || underflow;
        stall_cycles_d = stall_cycles_q + (id_stall ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sb_err_q       <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            sb_err_q       <= sb_err_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign sb_busy      = any_nz;
    assign sb_err       = sb_err_q;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_id_issue_scoreboard.sv
// Directed-step bench for id_issue_scoreboard; inputs change on the falling edge,
// outputs are checked 1 ns later.
module tb_id_issue_scoreboard;

    logic        clk, resetn;
    logic        id_valid, id_use_r1, id_use_r2, id_gr_we, id_br_taken, ex_allowin;
    logic [4:0]  id_raddr1, id_raddr2, id_dest;
    logic        wb_valid, wb_rf_we;
    logic [4:0]  wb_waddr;
    logic        id_allowin, id_to_ex_valid, id_stall, if_flush, sb_busy, sb_err;
    logic [31:0] stall_cycles;

    int checks = 0;
    int passed = 0;

    id_issue_scoreboard dut (
        .clk(clk), .resetn(resetn),
        .id_valid(id_valid), .id_raddr1(id_raddr1), .id_raddr2(id_raddr2),
        .id_use_r1(id_use_r1), .id_use_r2(id_use_r2), .id_gr_we(id_gr_we),
        .id_dest(id_dest), .id_br_taken(id_br_taken), .ex_allowin(ex_allowin),
        .wb_valid(wb_valid), .wb_rf_we(wb_rf_we), .wb_waddr(wb_waddr),
        .id_allowin(id_allowin), .id_to_ex_valid(id_to_ex_valid), .id_stall(id_stall),
        .if_flush(if_flush), .sb_busy(sb_busy), .sb_err(sb_err), .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // valid, raddr1, use1, raddr2, use2, gr_we, dest, br_taken, ex_allowin
    task automatic set_id(input logic v, input logic [4:0] r1, input logic u1,
                          input logic [4:0] r2, input logic u2, input logic we,
                          input logic [4:0] d, input logic br, input logic exa);
        id_valid = v; id_raddr1 = r1; id_use_r1 = u1; id_raddr2 = r2; id_use_r2 = u2;
        id_gr_we = we; id_dest = d; id_br_taken = br; ex_allowin = exa;
    endtask

    task automatic set_wb(input logic v, input logic [4:0] a);
        wb_valid = v; wb_rf_we = v; wb_waddr = a;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk_hs(input string tag, input logic to_ex, input logic allow, input logic stall);
        chk({tag, ".to_ex"}, {31'd0, id_to_ex_valid}, {31'd0, to_ex});
        chk({tag, ".allowin"}, {31'd0, id_allowin}, {31'd0, allow});
        chk({tag, ".stall"}, {31'd0, id_stall}, {31'd0, stall});
    endtask

    initial begin
        resetn = 1'b0;
        set_id(1, 5'd5, 1, 5'd0, 0, 1, 5'd5, 1, 1);
        set_wb(0, 5'd0);
        #2;
        chk_hs("rst", 0, 1, 0);
        chk("rst.flush", {31'd0, if_flush}, 32'd0);
        chk("rst.busy", {31'd0, sb_busy}, 32'd0);
        chk("rst.err", {31'd0, sb_err}, 32'd0);
        chk("rst.stallcnt", stall_cycles, 32'd0);

        step(); resetn = 1'b1; set_id(0, 0, 0, 0, 0, 0, 0, 0, 0); set_wb(0, 0);

        // Producer r5 then dependent consumer stalls through WB retire
        step(); set_id(1, 0, 0, 0, 0, 1, 5'd5, 0, 1); #1;
        chk_hs("t1.issue", 1, 1, 0);
        chk("t1.busy0", {31'd0, sb_busy}, 32'd0);
        step(); set_id(1, 5'd5, 1, 0, 0, 0, 0, 0, 1); #1;
        chk_hs("t1.raw", 0, 0, 1);
        chk("t1.busy1", {31'd0, sb_busy}, 32'd1);
        step(); #1; chk_hs("t1.raw2", 0, 0, 1);
        step(); #1; chk_hs("t1.raw3", 0, 0, 1);
        step(); set_wb(1, 5'd5); #1;
        chk_hs("t1.wbcyc", 0, 0, 1);
        step(); set_wb(0, 0); #1;
        chk_hs("t1.release", 1, 1, 0);
        chk("t1.stallcnt", stall_cycles, 32'd4);
        chk("t1.busy2", {31'd0, sb_busy}, 32'd0);

        // Three writers to r7 fill the counter; a fourth is held until one retires
        for (int i = 0; i < 3; i++) begin
            step(); set_id(1, 0, 0, 0, 0, 1, 5'd7, 0, 1); #1;
            chk("t2.wr", {31'd0, id_to_ex_valid}, 32'd1);
        end
        step(); #1; chk_hs("t2.full", 0, 0, 1);
        step(); set_wb(1, 5'd7); #1; chk_hs("t2.fullwb", 0, 0, 1);
        step(); set_wb(0, 0); #1; chk_hs("t2.go", 1, 1, 0);
        step(); #1; chk_hs("t2.full_again", 0, 0, 1);
        step(); set_id(0, 0, 0, 0, 0, 0, 0, 0, 0); set_wb(1, 5'd7); #1;
        chk("t2.stallcnt", stall_cycles, 32'd7);
        step(); #1;
        step(); #1; chk("t2.busy_last", {31'd0, sb_busy}, 32'd1);
        step(); set_wb(0, 0); #1;
        chk("t2.drained", {31'd0, sb_busy}, 32'd0);
        chk("t2.err", {31'd0, sb_err}, 32'd0);

        // Same-register inc/dec cancels; different registers update independently
        step(); set_id(1, 0, 0, 0, 0, 1, 5'd9, 0, 1); #1;
        step(); set_wb(1, 5'd9); #1; chk("t3.same_issue", {31'd0, id_to_ex_valid}, 32'd1);
        step(); set_id(1, 5'd9, 1, 0, 0, 0, 0, 0, 1); #1;
        chk_hs("t3.cnt9_nz", 0, 0, 1);
        step(); set_wb(0, 0); #1;
        chk_hs("t3.cnt9_was1", 1, 1, 0);
        chk("t3.busy", {31'd0, sb_busy}, 32'd0);
        step(); set_id(1, 0, 0, 0, 0, 1, 5'd4, 0, 1); #1;
        step(); set_id(1, 0, 0, 0, 0, 1, 5'd9, 0, 1); set_wb(1, 5'd4); #1;
        chk("t3.diff_issue", {31'd0, id_to_ex_valid}, 32'd1);
        step(); set_id(1, 5'd4, 1, 0, 0, 0, 0, 0, 1); set_wb(0, 0); #1;
        chk_hs("t3.r4_clear", 1, 1, 0);
        step(); set_id(1, 0, 0, 5'd9, 1, 0, 0, 0, 1); set_wb(1, 5'd9); #1;
        chk_hs("t3.r9_pending", 0, 0, 1);
        step(); set_id(0, 0, 0, 0, 0, 0, 0, 0, 0); set_wb(0, 0); #1;
        chk("t3.busy_end", {31'd0, sb_busy}, 32'd0);

        // Taken branch flush pulse
        step(); set_id(1, 0, 0, 0, 0, 0, 0, 1, 1); #1;
        chk("t4.flush", {31'd0, if_flush}, 32'd1);
        chk("t4.issue", {31'd0, id_to_ex_valid}, 32'd1);
        step(); set_id(1, 0, 0, 0, 0, 0, 0, 0, 1); #1;
        chk("t4.flush_once", {31'd0, if_flush}, 32'd0);
        step(); set_id(1, 0, 0, 0, 0, 0, 0, 1, 0); #1;
        chk("t4.flush_blocked", {31'd0, if_flush}, 32'd0);
        chk_hs("t4.blocked", 0, 0, 0);

        // r0 is never tracked; retire with empty counter sets sticky error
        step(); set_id(1, 5'd0, 1, 5'd0, 1, 1, 5'd0, 0, 1); #1;
        chk_hs("t5.r0", 1, 1, 0);
        step(); #1;
        chk_hs("t5.r0_again", 1, 1, 0);
        chk("t5.busy", {31'd0, sb_busy}, 32'd0);
        step(); set_id(0, 0, 0, 0, 0, 0, 0, 0, 0); set_wb(1, 5'd3); #1;
        chk("t5.err_pre", {31'd0, sb_err}, 32'd0);
        step(); set_wb(0, 0); #1;
        chk("t5.err", {31'd0, sb_err}, 32'd1);
        chk("t5.busy_after", {31'd0, sb_busy}, 32'd0);
        step(); set_id(1, 5'd3, 1, 0, 0, 0, 0, 0, 1); #1;
        chk("t5.err_held", {31'd0, sb_err}, 32'd1);
        chk_hs("t5.r3_zero", 1, 1, 0);

        // Async reset mid-stall discards pending writes to r5
        step(); set_id(1, 0, 0, 0, 0, 1, 5'd5, 0, 1); #1;
        step(); #1;
        step(); set_id(1, 5'd5, 1, 0, 0, 0, 0, 0, 1); #1;
        chk_hs("t6.stall", 0, 0, 1);
        #2 resetn = 1'b0;
        #1;
        chk_hs("t6.inrst", 0, 1, 0);
        chk("t6.flush", {31'd0, if_flush}, 32'd0);
        chk("t6.busy", {31'd0, sb_busy}, 32'd0);
        chk("t6.err", {31'd0, sb_err}, 32'd0);
        chk("t6.stallcnt", stall_cycles, 32'd0);
        step(); resetn = 1'b1; #1;
        chk_hs("t6.after", 1, 1, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
